// File: rtl/sprite_update_sched.sv
// sprite_update_sched: two requester FIFOs feeding the sprite-engine register
// write bus. Queued writes are held until vblank opens (vsync rise), then
// drained round-robin, one write per cycle, up to BUDGET writes per window.
//
// state   | meaning
// IDLE    | nothing queued or scheduler disabled
// WAIT_VB | writes queued, waiting for the vsync rising edge
// DRAIN   | vblank window open, one register write per cycle
// DONE    | window closed, single-cycle commit_done pulse
module sprite_update_sched #(
  parameter int DEPTH  = 4,
  parameter int BUDGET = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_addr,
  input  logic [15:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_addr,
  input  logic [15:0] req1_data,
  input  logic        enable,
  input  logic        vsync,
  output logic [1:0]  eng_write_n,
  output logic [5:0]  eng_address,
  output logic [15:0] eng_data,
  output logic        busy,
  output logic        commit_done,
  output logic        ovf,
  input  logic        ovf_clr
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [7:0]  BUDGET_CNT = 8'(BUDGET);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_VB = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [21:0]   mem0 [DEPTH];
  logic [21:0]   mem1 [DEPTH];
  logic [AW-1:0] wptr0, rptr0, wptr1, rptr1;
  logic [AW:0]   cnt0, cnt1, cnt0_nxt, cnt1_nxt;
  logic          push0, push1, pop0, pop1, pop_any, can_pop;
  logic          vsync_d, vs_rise, vs_fall;
  logic          last_rr;
  logic [7:0]    wcnt, wcnt_nxt;
  logic          drain_exit, ovf_set;
  logic [21:0]   pop_entry;

  assign req0_ready  = (cnt0 != FULL_CNT);
  assign req1_ready  = (cnt1 != FULL_CNT);
  assign push0       = req0_valid && req0_ready;
  assign push1       = req1_valid && req1_ready;
  assign vs_rise     = vsync && !vsync_d;
  assign vs_fall     = !vsync && vsync_d;
  assign busy        = (state != IDLE);
  assign commit_done = (state == DONE);

  // Round-robin pick of at most one requester to pop while the window is open.
  always_comb begin
    pop0    = 1'b0;
    pop1    = 1'b0;
    can_pop = (state == DRAIN) && enable && !vs_fall && (wcnt < BUDGET_CNT);
    if (can_pop) begin
      if (cnt0 != '0 && cnt1 != '0) begin
        pop0 = last_rr;
        pop1 = !last_rr;
      end else if (cnt0 != '0) begin
        pop0 = 1'b1;
      end else if (cnt1 != '0) begin
        pop1 = 1'b1;
      end
    end
  end

  assign pop_any   = pop0 || pop1;
  assign pop_entry = pop0 ? mem0[rptr0] : mem1[rptr1];
  assign cnt0_nxt  = cnt0 + (AW+1)'(push0) - (AW+1)'(pop0);
  assign cnt1_nxt  = cnt1 + (AW+1)'(push1) - (AW+1)'(pop1);
  assign wcnt_nxt  = (pop_any && wcnt != BUDGET_CNT) ? wcnt + 8'd1 : wcnt;

  // Window closes once nothing is left, the budget is spent, vblank ends or we are disabled.
  assign drain_exit = (state == DRAIN) &&
                      ((cnt0_nxt == '0 && cnt1_nxt == '0) || wcnt_nxt == BUDGET_CNT ||
                       vs_fall || !enable);
  assign ovf_set    = drain_exit && (wcnt_nxt == BUDGET_CNT) &&
                      (cnt0_nxt != '0 || cnt1_nxt != '0);

  // Next-state decode for the vblank sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && (cnt0 != '0 || cnt1 != '0)) state_nxt = WAIT_VB;
      WAIT_VB: begin
        if (!enable)      state_nxt = IDLE;
        else if (vs_rise) state_nxt = DRAIN;
      end
      DRAIN:   if (drain_exit) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state, vsync history, arbitration pointer and window write count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vsync_d <= 1'b0;
      last_rr <= 1'b1;
      wcnt    <= '0;
    end else begin
      state   <= state_nxt;
      vsync_d <= vsync;
      if (pop_any) last_rr <= pop1;
      if (state == WAIT_VB && state_nxt == DRAIN) wcnt <= '0;
      else                                        wcnt <= wcnt_nxt;
    end
  end

  // FIFO pointers and occupancy for both requesters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr0 <= '0;
      rptr0 <= '0;
      cnt0  <= '0;
      wptr1 <= '0;
      rptr1 <= '0;
      cnt1  <= '0;
    end else begin
      if (push0) wptr0 <= wptr0 + AW'(1);
      if (pop0)  rptr0 <= rptr0 + AW'(1);
      if (push1) wptr1 <= wptr1 + AW'(1);
      if (pop1)  rptr1 <= rptr1 + AW'(1);
      cnt0 <= cnt0_nxt;
      cnt1 <= cnt1_nxt;
    end
  end

  // FIFO storage; contents are qualified by the counts so no reset is needed.
  always_ff @(posedge clk) begin
    if (push0) mem0[wptr0] <= {req0_addr, req0_data};
    if (push1) mem1[wptr1] <= {req1_addr, req1_data};
  end

  // Present the popped entry on the engine bus one cycle later; address/data hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      eng_write_n <= 2'b11;
      eng_address <= '0;
      eng_data    <= '0;
    end else begin
      eng_write_n <= pop_any ? 2'b01 : 2'b11;
      if (pop_any) {eng_address, eng_data} <= pop_entry;
    end
  end

  // Sticky overflow flag; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_sprite_update_sched.sv
// tb_sprite_update_sched: directed scenarios for the sprite update scheduler,
// compared cycle by cycle against a queue-based reference model.
module tb_sprite_update_sched;

  localparam int DEPTH  = 4;
  localparam int BUDGET = 4;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        enable, vsync, ovf_clr;
  logic [1:0]  eng_write_n;
  logic [5:0]  eng_address;
  logic [15:0] eng_data;
  logic        busy, commit_done, ovf;

  sprite_update_sched #(.DEPTH(DEPTH), .BUDGET(BUDGET)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .enable(enable), .vsync(vsync),
    .eng_write_n(eng_write_n), .eng_address(eng_address), .eng_data(eng_data),
    .busy(busy), .commit_done(commit_done), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  // reference model state
  logic [21:0] q0[$];
  logic [21:0] q1[$];
  bit          m_wait, m_win, m_done, m_last1, m_vs_prev;
  int          m_wcnt;
  logic [1:0]  e_wn = 2'b11;
  logic [5:0]  e_addr = '0;
  logic [15:0] e_data = '0;
  logic        e_ovf = 1'b0;

  // observed bus activity
  logic [21:0] w_log[$];
  int          w_cyc[$];
  int          done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [21:0] mk(input int a, input int d);
    logic [5:0]  a6;
    logic [15:0] d16;
    a6  = a[5:0];
    d16 = d[15:0];
    return {a6, d16};
  endfunction

  task automatic model_step();
    logic [21:0] e;
    bit rise, fall, p0, p1, any_before, take0, take1, set_ovf;
    if (rst) begin
      q0.delete();
      q1.delete();
      m_wait = 0; m_win = 0; m_done = 0; m_last1 = 1; m_wcnt = 0; m_vs_prev = 0;
      e_wn = 2'b11; e_addr = '0; e_data = '0; e_ovf = 1'b0;
    end else begin
      rise       = vsync && !m_vs_prev;
      fall       = !vsync && m_vs_prev;
      any_before = (q0.size() != 0) || (q1.size() != 0);
      p0         = req0_valid && (q0.size() < DEPTH);
      p1         = req1_valid && (q1.size() < DEPTH);
      take0 = 0;
      take1 = 0;
      set_ovf = 0;
      if (m_win && enable && !fall && m_wcnt < BUDGET) begin
        if (q0.size() != 0 && q1.size() != 0) begin
          take0 = m_last1;
          take1 = !m_last1;
        end else begin
          take0 = (q0.size() != 0);
          take1 = (q1.size() != 0);
        end
      end
      e_wn = 2'b11;
      if (take0 || take1) begin
        if (take0) e = q0.pop_front();
        else       e = q1.pop_front();
        e_wn    = 2'b01;
        e_addr  = e[21:16];
        e_data  = e[15:0];
        m_last1 = take1;
        m_wcnt++;
      end
      if (p0) q0.push_back({req0_addr, req0_data});
      if (p1) q1.push_back({req1_addr, req1_data});
      if (m_win) begin
        if ((q0.size() == 0 && q1.size() == 0) || m_wcnt == BUDGET || fall || !enable) begin
          m_win  = 0;
          m_done = 1;
          set_ovf = (m_wcnt == BUDGET) && (q0.size() != 0 || q1.size() != 0);
        end
      end else if (m_wait) begin
        if (!enable) m_wait = 0;
        else if (rise) begin
          m_wait = 0;
          m_win  = 1;
          m_wcnt = 0;
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (enable && any_before) begin
        m_wait = 1;
      end
      if (set_ovf)      e_ovf = 1'b1;
      else if (ovf_clr) e_ovf = 1'b0;
      m_vs_prev = vsync;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("eng_write_n", eng_write_n, e_wn);
      chk("eng_address", eng_address, e_addr);
      chk("eng_data", eng_data, e_data);
      chk("busy", busy, m_wait || m_win || m_done);
      chk("commit_done", commit_done, m_done);
      chk("ovf", ovf, e_ovf);
      chk("req0_ready", req0_ready, q0.size() < DEPTH);
      chk("req1_ready", req1_ready, q1.size() < DEPTH);
    end
    if (eng_write_n == 2'b01) begin
      w_log.push_back({eng_address, eng_data});
      w_cyc.push_back(cyc);
    end
    if (commit_done == 1'b1) done_cnt++;
  end

  task automatic push(input bit v0, input bit v1, input logic [21:0] e0, input logic [21:0] e1);
    req0_valid = v0;
    {req0_addr, req0_data} = e0;
    req1_valid = v1;
    {req1_addr, req1_data} = e1;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_write();
    int n = 0;
    while (eng_write_n !== 2'b01 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("write_timeout", eng_write_n, 2'b01);
  endtask

  initial begin
    int base, d0, rise_cyc;
    logic [21:0] exp6 [6];
    rst = 1'b1; enable = 1'b0; vsync = 1'b0; ovf_clr = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1;

    chk("rst_write_n", eng_write_n, 2'b11);
    chk("rst_addr", eng_address, 0);
    chk("rst_data", eng_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ready0", req0_ready, 1);
    chk("rst_ready1", req1_ready, 1);

    // two req0 writes, one vblank
    enable = 1'b1;
    base = w_log.size();
    d0 = done_cnt;
    push(1, 0, mk('h04, 'h1020), '0);
    push(1, 0, mk('h06, 'hAAAA), '0);
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    rise_cyc = cyc;
    repeat (6) @(negedge clk);
    vsync = 1'b0;
    wait_idle();
    chk("t1_count", w_log.size() - base, 2);
    chk("t1_w0", w_log[base], 22'h04_1020);
    chk("t1_w1", w_log[base+1], 22'h06_AAAA);
    chk("t1_lat0", w_cyc[base] - rise_cyc, 2);
    chk("t1_lat1", w_cyc[base+1] - rise_cyc, 3);
    chk("t1_done", done_cnt - d0, 1);

    // round-robin over two windows with budget overflow
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = w_log.size();
    for (int k = 0; k < 3; k++) begin
      exp6[2*k]   = mk('h10 + k, 'hA000 + k);
      exp6[2*k+1] = mk('h20 + k, 'hB000 + k);
      push(1, 1, exp6[2*k], exp6[2*k+1]);
    end
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (8) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    chk("t2_first_count", w_log.size() - base, 4);
    chk("t2_ovf_set", ovf, 1);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    wait_idle();
    chk("t2_count", w_log.size() - base, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("t2_order%0d", k), w_log[base+k], exp6[k]);
    chk("t2_ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t2_ovf_clr", ovf, 0);

    // vsync falls after two writes
    base = w_log.size();
    push(1, 1, mk('h30, 'hC000), mk('h31, 'hD000));
    for (int k = 1; k < 4; k++) push(1, 0, mk('h30, 'hC000 + k), '0);
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_first_count", w_log.size() - base, 2);
    chk("t3_w0", w_log[base], 22'h30_C000);
    chk("t3_w1", w_log[base+1], 22'h31_D000);
    chk("t3_no_ovf", ovf, 0);
    vsync = 1'b1;
    repeat (6) @(negedge clk);
    vsync = 1'b0;
    wait_idle();
    chk("t3_count", w_log.size() - base, 5);
    chk("t3_w2", w_log[base+2], 22'h30_C001);
    chk("t3_w3", w_log[base+3], 22'h30_C002);
    chk("t3_w4", w_log[base+4], 22'h30_C003);

    // fill req1, extra push ignored
    enable = 1'b0;
    base = w_log.size();
    for (int k = 0; k < 4; k++) push(0, 1, '0, mk('h08 + k, 'hF000 + k));
    chk("t4_full", req1_ready, 0);
    push(0, 1, '0, mk('h3F, 'hDEAD));
    chk("t4_still_full", req1_ready, 0);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    wait_write();
    chk("t4_ready_back", req1_ready, 1);
    repeat (6) @(negedge clk);
    vsync = 1'b0;
    wait_idle();
    chk("t4_count", w_log.size() - base, 4);
    chk("t4_w0", w_log[base], 22'h08_F000);
    chk("t4_w3", w_log[base+3], 22'h0B_F003);
    chk("t4_no_ovf", ovf, 0);

    // reset mid-window
    base = w_log.size();
    d0 = done_cnt;
    for (int k = 0; k < 3; k++) push(1, 0, mk('h01 + k, 'h5000 + k), '0);
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    wait_write();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_write_n", eng_write_n, 2'b11);
    chk("t5_busy", busy, 0);
    chk("t5_ready0", req0_ready, 1);
    vsync = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_count", w_log.size() - base, 1);
    chk("t5_no_done", done_cnt - d0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
